// File: rtl/rr_pkt_mux.sv
// rr_pkt_mux: N-source round-robin packet multiplexer with one registered
// output stage. A winner is chosen in IDLE, locked for the whole packet
// (until its s_last beat is accepted), and only then does priority rotate
// past it. One arbitration bubble is spent per packet.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_valid/s_last    per-source beat valid / last-beat flag
//   s_data            source i data at [i*DW +: DW]
//   s_ready           per-source accept, only the lock owner can be ready
//   m_valid/m_data/m_last/m_src  registered output beat and its source ID
//   m_ready           downstream accept
//   gnt               registered one-hot owner, zero when idle

// Per-source ready: only the owner, and only while the output can take a beat.
module rr_pkt_mux_lane #(
  parameter int IW  = 3,
  parameter int IDX = 0
) (
  input  logic          locked,
  input  logic [IW-1:0] sel,
  input  logic          out_free,
  output logic          ready
);
  assign ready = locked && (sel == IW'(IDX)) && out_free;
endmodule

module rr_pkt_mux #(
  parameter int N  = 8,
  parameter int DW = 32,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]    s_valid,
  input  logic [N*DW-1:0] s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic [IW-1:0]   m_src,
  input  logic            m_ready,
  output logic [N-1:0]    gnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]           state;
  logic [N-1:0]         pri;
  logic [IW-1:0]        sel, win, pidx, sel_inc;
  logic                 any_req, out_free, locked, s_hs, s_end;
  logic [N-1:0][DW-1:0] data_v;
  int                   idx;

  assign data_v = s_data;

  // Winner: first requester at or above pri's position, wrapping N-1 -> 0.
  always_comb begin
    pidx    = '0;
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++)
      if (pri[i]) pidx = IW'(i);
    for (int k = 0; k < N; k++) begin
      idx = int'(pidx) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && s_valid[idx]) begin
        win     = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign sel_inc  = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
  assign out_free = !m_valid || m_ready;
  assign locked   = (state == LOCK);
  assign s_hs     = locked && s_valid[sel] && out_free;
  assign s_end    = s_hs && s_last[sel];

  // s_ready depends only on state/sel/output occupancy, never on s_valid.
  for (genvar g = 0; g < N; g++) begin : g_lane
    rr_pkt_mux_lane #(.IW(IW), .IDX(g)) u_lane (
      .locked   (locked),
      .sel      (sel),
      .out_free (out_free),
      .ready    (s_ready[g])
    );
  end

  // Arbitration / lock. Priority moves only when a packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pri   <= ONE;
      sel   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state <= LOCK;
          sel   <= win;
          gnt   <= ONE << win;
        end
        LOCK: if (s_end) begin
          state <= IDLE;
          gnt   <= '0;
          pri   <= ONE << sel_inc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on source handshake (also when draining the
  // current beat the same cycle), otherwise drop valid once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (s_hs) begin
      m_valid <= 1'b1;
      m_data  <= data_v[sel];
      m_last  <= s_last[sel];
      m_src   <= sel;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_pkt_mux.sv
module tb_rr_pkt_mux;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_valid = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]    s_last = '0;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [IW-1:0]   m_src;
  logic            m_ready = 1'b1;
  logic [N-1:0]    gnt;

  rr_pkt_mux #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .m_ready(m_ready), .gnt(gnt)
  );

  always #5 clk = ~clk;

  // Source models: a small beat table per source, gated by src_en.
  logic [DW-1:0] src_dat [N][8];
  logic          src_lst [N][8];
  int            src_len [N];
  int            src_ptr [N];
  logic          src_en  [N];
  logic [N-1:0]  hs_rec;
  logic          mr_q [$];
  logic [DW+IW:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Driver: all inputs change on the falling edge; handshakes recorded
  // mid-cycle are retired at the next falling edge.
  initial begin
    hs_rec = '0;
    forever begin
      @(negedge clk);
      if (!rst)
        for (int i = 0; i < N; i++) if (hs_rec[i]) src_ptr[i]++;
      for (int i = 0; i < N; i++) begin
        if (src_en[i] && src_ptr[i] < src_len[i]) begin
          s_valid[i] = 1'b1;
          s_data[i*DW +: DW] = src_dat[i][src_ptr[i]];
          s_last[i] = src_lst[i][src_ptr[i]];
        end else begin
          s_valid[i] = 1'b0;
          s_data[i*DW +: DW] = '0;
          s_last[i] = 1'b0;
        end
      end
      m_ready = (mr_q.size() != 0) ? mr_q.pop_front() : 1'b1;
      #1;
      hs_rec = s_valid & s_ready;
    end
  end

  // Monitor: every output handshake is checked against the scoreboard.
  initial begin
    logic [DW+IW:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {m_src, m_last, m_data}, '0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {m_src, m_last, m_data}, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic load(input int s, input int n, input logic [DW-1:0] base,
                      input logic [7:0] lmask);
    for (int b = 0; b < n; b++) begin
      src_dat[s][b] = base + DW'(b);
      src_lst[s][b] = lmask[b];
    end
    src_ptr[s] = 0;
    src_len[s] = n;
    src_en[s]  = 1'b1;
  endtask

  task automatic expb(input int s, input logic [DW-1:0] d, input logic l);
    exp_q.push_back({IW'(s), l, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_ptr[i] = 0; src_en[i] = 1'b0; end
    mr_q.delete();
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin tick(); c++; end
    chk(name, 64'(exp_q.size()), 0);
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0; src_ptr[i] = 0; src_en[i] = 1'b0;
      for (int b = 0; b < 8; b++) begin src_dat[i][b] = '0; src_lst[i][b] = 1'b0; end
    end
    // 1: reset then idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_gnt", 64'(gnt), 0);
      chk("idle_s_ready", 64'(s_ready), 0);
      chk("idle_m_valid", 64'(m_valid), 0);
    end

    // 2: source 3, 4-beat packet, latency and lock
    load(3, 4, 32'hA0, 8'b1000);
    for (int b = 0; b < 4; b++) expb(3, 32'hA0 + DW'(b), b == 3);
    tick(); chk("t2_c0_gnt", 64'(gnt), 0); chk("t2_c0_rdy", 64'(s_ready), 0);
    tick(); chk("t2_c1_gnt", 64'(gnt), 8'h08); chk("t2_c1_rdy", 64'(s_ready), 8'h08);
            chk("t2_c1_mv", 64'(m_valid), 0);
    tick(); chk("t2_c2_mv", 64'(m_valid), 1); chk("t2_c2_src", 64'(m_src), 3);
            chk("t2_c2_data", 64'(m_data), 32'hA0); chk("t2_c2_last", 64'(m_last), 0);
    tick(); tick();
    tick(); chk("t2_c5_data", 64'(m_data), 32'hA3); chk("t2_c5_last", 64'(m_last), 1);
            chk("t2_c5_gnt", 64'(gnt), 0);
    tick(); chk("t2_c6_mv", 64'(m_valid), 0);
    drain("t2_drain", 20);
    // priority now at source 4: 4 must beat 1
    load(1, 1, 32'h11, 8'b1); load(4, 1, 32'h44, 8'b1);
    expb(4, 32'h44, 1'b1); expb(1, 32'h11, 1'b1);
    drain("t2_pri_drain", 20);

    // 3: all sources with 2-beat packets, source 0 has a second packet
    do_reset();
    for (int s = 1; s < N; s++) load(s, 2, 32'h3000 + DW'(s * 16), 8'b10);
    load(0, 4, 32'h3000, 8'b1010);
    for (int s = 0; s < N; s++) begin
      expb(s, 32'h3000 + DW'(s * 16), 1'b0);
      expb(s, 32'h3001 + DW'(s * 16), 1'b1);
    end
    expb(0, 32'h3002, 1'b0); expb(0, 32'h3003, 1'b1);
    drain("t3_drain", 100);

    // 4: backpressure mid-packet on source 1
    do_reset();
    load(1, 4, 32'hB0, 8'b1000);
    for (int b = 0; b < 4; b++) expb(1, 32'hB0 + DW'(b), b == 3);
    mr_q.push_back(1'b1); mr_q.push_back(1'b1); mr_q.push_back(1'b1);
    mr_q.push_back(1'b0); mr_q.push_back(1'b0); mr_q.push_back(1'b1);
    tick(); tick(); tick();
    tick(); chk("t4_c3_data", 64'(m_data), 32'hB1); chk("t4_c3_rdy", 64'(s_ready), 0);
    tick(); chk("t4_c4_data", 64'(m_data), 32'hB1); chk("t4_c4_src", 64'(m_src), 1);
            chk("t4_c4_last", 64'(m_last), 0); chk("t4_c4_rdy", 64'(s_ready), 0);
            chk("t4_c4_mv", 64'(m_valid), 1);
    tick(); chk("t4_c5_data", 64'(m_data), 32'hB1); chk("t4_c5_rdy", 64'(s_ready), 8'h02);
    drain("t4_drain", 20);

    // 5: owner 5 stalls mid-packet while 2 and 6 request
    do_reset();
    load(5, 4, 32'h50, 8'b1000);
    for (int b = 0; b < 4; b++) expb(5, 32'h50 + DW'(b), b == 3);
    expb(6, 32'h66, 1'b1); expb(2, 32'h22, 1'b1);
    tick(); tick();
    src_en[5] = 1'b0;
    load(2, 1, 32'h22, 8'b1); load(6, 1, 32'h66, 8'b1);
    for (int c = 0; c < 3; c++) begin
      tick(); chk("t5_gnt", 64'(gnt), 8'h20); chk("t5_rdy", 64'(s_ready), 8'h20);
    end
    src_en[5] = 1'b1;
    drain("t5_drain", 30);

    // 6: reset during beat 2 of a source-6 packet
    do_reset();
    load(6, 4, 32'h60, 8'b1000);
    expb(6, 32'h60, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_en[i] = 1'b0; end
    #1;
    chk("t6_rst_mv", 64'(m_valid), 0); chk("t6_rst_rdy", 64'(s_ready), 0);
    chk("t6_rst_gnt", 64'(gnt), 0); chk("t6_rst_q", 64'(exp_q.size()), 0);
    tick();
    rst = 1'b0;
    load(6, 1, 32'h6A, 8'b1); load(0, 1, 32'h0A, 8'b1);
    expb(0, 32'h0A, 1'b1); expb(6, 32'h6A, 1'b1);
    drain("t6_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
